dac_spi_tx: RTL and testbench

- Output-side serial transmitter for the loop controller.
- Takes the controller's 12-bit output word and its completion strobe, which is used as this block's start.
- Shifts a 16-bit frame to an AD5320-class serial DAC over a 3-wire interface (SYNC_n/SCLK/DIN).
- Emits a one-cycle done pulse that serves as the start for the next stage, e.g. the next ADC conversion.

---
 rtl/dac_pkg.sv | 21 ++
 rtl/rise_edge_det.sv | 31 +++
 rtl/dac_spi_tx.sv | 164 ++++++++++++++++
 tb/tb_dac_spi_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC transmitter: frame width,
// AD5320 power-down field codes and the transmitter FSM states.
`timescale 1ns/1ps
package dac_pkg;

    localparam int unsigned FRAME_W = 16;

    // AD5320 power-down field codes
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_TRI    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/rise_edge_det.sv
// Two-flop start synchronizer and rising-edge detector.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset (clears both flops)
//   d_i      - asynchronous/level input
//   rise_c_o - combinational rising-edge flag, true for one cycle
`timescale 1ns/1ps
module rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_c_o
);

    logic s0_q;
    logic s1_q;

    // Shift the input through two flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            s0_q <= d_i;
            s1_q <= s0_q;
        end
    end

    assign rise_c_o = s0_q & ~s1_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Serial transmitter for an AD5320-class DAC. A rising edge on start
// captures u_in into the frame {2'b00, PD_MODE, u_in} and shifts it out
// MSB first over SYNC_n/SCLK/DIN, then pulses done after a short hold.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   start       - upstream completion level; frames start on its rise
//   u_in        - DAC code, captured when the frame starts
//   dac_sync_n  - frame select, active low
//   dac_sclk    - serial clock, idles high, DAC samples on falling edge
//   dac_din     - serial data, MSB first
//   busy        - high while a frame is in progress
//   done        - one-cycle pulse at end of frame
`timescale 1ns/1ps
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned W        = 11,
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [1:0]  PD_MODE  = PD_NORMAL,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [W:0] u_in,
    output logic       dac_sync_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned BIT_W  = $clog2(FRAME_W);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   sr_q, sr_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 sync_n_q, sync_n_d;
    logic                 sclk_q, sclk_d;
    logic                 din_q, din_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 rise_c;
    logic [FRAME_W-1:0]   frame_c;

    rise_edge_det u_start_det (
        .clk      (clk),
        .reset    (reset),
        .d_i      (start),
        .rise_c_o (rise_c)
    );

    assign frame_c = FRAME_W'({2'b00, PD_MODE, u_in});

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            hold_q   <= '0;
            sync_n_q <= 1'b1;
            sclk_q   <= 1'b1;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            hold_q   <= hold_d;
            sync_n_q <= sync_n_d;
            sclk_q   <= sclk_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        div_d    = div_q;
        bit_d    = bit_q;
        hold_d   = hold_q;
        sync_n_d = sync_n_q;
        sclk_d   = sclk_q;
        din_d    = din_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_c) begin
                    sr_d     = frame_c;
                    sync_n_d = 1'b0;
                    din_d    = frame_c[FRAME_W-1];
                    busy_d   = 1'b1;
                    bit_d    = '0;
                    div_d    = '0;
                    state_d  = SHIFT;
                end
            end

            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Falling edge: DAC samples the current bit
                        sclk_d = 1'b0;
                    end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        // Rising edge after the last bit closes the frame
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        hold_d   = '0;
                        state_d  = HOLD;
                    end else begin
                        // Rotate rather than shift; the wrapped bit is never sent
                        sclk_d = 1'b1;
                        sr_d   = {sr_q[FRAME_W-2:0], sr_q[FRAME_W-1]};
                        din_d  = sr_q[FRAME_W-2];
                        bit_d  = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dac_sync_n = sync_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three configurations share one stimulus stream
// and are compared every cycle against a timing model expressed as
// "cycles since the frame began", plus literal frame/latency checks.
`timescale 1ns/1ps
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] u_in;
    logic [2:0]  sync_n, sclk, din, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int k_rise = 0;

    // Model state per instance
    logic        m_act [3];
    int          m_t   [3];
    logic        m_s0  [3];
    logic        m_s1  [3];
    logic [15:0] m_frame [3];

    // Observation of the serial lines per instance
    logic [15:0] cap [3];
    logic [15:0] last_word [3];
    int          low_cnt [3];
    int          last_low [3];
    logic        prev_sclk [3];
    logic        prev_sync [3];
    logic        sclk_at_rise [3];
    int          done_cnt [3];
    int          done_cyc [3];

    logic        st_smp, rst_smp;
    logic [11:0] u_smp;

    dac_spi_tx #(.W(11), .CLK_DIV(4), .PD_MODE(2'b00), .HOLD_CYC(2)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .u_in(u_in),
        .dac_sync_n(sync_n[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
        .busy(busy[0]), .done(done[0]));

    dac_spi_tx #(.W(11), .CLK_DIV(3), .PD_MODE(2'b11), .HOLD_CYC(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .u_in(u_in),
        .dac_sync_n(sync_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
        .busy(busy[1]), .done(done[1]));

    dac_spi_tx #(.W(11), .CLK_DIV(1), .PD_MODE(2'b00), .HOLD_CYC(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .u_in(u_in),
        .dac_sync_n(sync_n[2]), .dac_sclk(sclk[2]), .dac_din(din[2]),
        .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;

    function automatic int cdiv(input int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int hcyc(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic logic [1:0] pdm(input int i);
        return (i == 1) ? 2'b11 : 2'b00;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    // One clock: sample inputs at posedge, advance model and compare at negedge
    task automatic tick();
        int   c, h, l;
        logic rise;
        logic e_sync, e_sclk, e_din, e_busy, e_done;
        @(posedge clk);
        st_smp  = start;
        u_smp   = u_in;
        rst_smp = reset;
        cyc++;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            c = cdiv(i);
            h = hcyc(i);
            l = 32 * c;
            if (rst_smp) begin
                m_act[i] = 1'b0;
                m_t[i]   = 0;
                m_s0[i]  = 1'b0;
                m_s1[i]  = 1'b0;
            end else begin
                rise = m_s0[i] & ~m_s1[i];
                if (m_act[i]) begin
                    if (m_t[i] == l + h) m_act[i] = 1'b0;
                    else                 m_t[i]++;
                end else if (rise) begin
                    m_act[i]   = 1'b1;
                    m_t[i]     = 0;
                    m_frame[i] = {2'b00, pdm(i), u_smp};
                end
                m_s1[i] = m_s0[i];
                m_s0[i] = st_smp;
            end

            if (m_act[i] && m_t[i] < l) begin
                e_sync = 1'b0;
                e_sclk = ((m_t[i] / c) % 2) == 0;
                e_din  = m_frame[i][15 - m_t[i] / (2 * c)];
                e_busy = 1'b1;
                e_done = 1'b0;
            end else if (m_act[i]) begin
                e_sync = 1'b1;
                e_sclk = 1'b1;
                e_din  = 1'b0;
                e_busy = 1'b1;
                e_done = (m_t[i] == l + h);
            end else begin
                e_sync = 1'b1;
                e_sclk = 1'b1;
                e_din  = 1'b0;
                e_busy = 1'b0;
                e_done = 1'b0;
            end
            chk("sync_n", i, 32'(sync_n[i]), 32'(e_sync));
            chk("sclk",   i, 32'(sclk[i]),   32'(e_sclk));
            chk("din",    i, 32'(din[i]),    32'(e_din));
            chk("busy",   i, 32'(busy[i]),   32'(e_busy));
            chk("done",   i, 32'(done[i]),   32'(e_done));

            if (!sync_n[i] && prev_sclk[i] && !sclk[i]) cap[i] = {cap[i][14:0], din[i]};
            if (!sync_n[i]) low_cnt[i]++;
            if (sync_n[i] && !prev_sync[i]) begin
                last_word[i]    = cap[i];
                last_low[i]     = low_cnt[i];
                sclk_at_rise[i] = sclk[i];
                cap[i]          = '0;
                low_cnt[i]      = 0;
            end
            if (done[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
            prev_sclk[i] = sclk[i];
            prev_sync[i] = sync_n[i];
        end
    endtask

    task automatic pulse(input logic [11:0] v, input int hi);
        u_in  = v;
        start = 1'b1;
        tick();
        k_rise = cyc;
        repeat (hi - 1) tick();
        start = 1'b0;
    endtask

    initial begin
        int d0, d1, d2, gap;
        reset = 1'b1;
        start = 1'b0;
        u_in  = '0;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_s0[i] = 1'b0; m_s1[i] = 1'b0; m_frame[i] = '0;
            cap[i] = '0; last_word[i] = '0; low_cnt[i] = 0; last_low[i] = 0;
            prev_sclk[i] = 1'b1; prev_sync[i] = 1'b1; sclk_at_rise[i] = 1'b0;
            done_cnt[i] = 0; done_cyc[i] = 0;
        end
        repeat (3) tick();
        chk("rst_sync_n", 0, 32'(sync_n[0]), 32'd1);
        chk("rst_sclk",   0, 32'(sclk[0]),   32'd1);
        chk("rst_din",    0, 32'(din[0]),    32'd0);
        chk("rst_busy",   0, 32'(busy[0]),   32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Basic frame
        d0 = done_cnt[0];
        pulse(12'hC1F, 3);
        repeat (150) tick();
        chk("wordA",      0, 32'(last_word[0]), 32'h0C1F);
        chk("lowA",       0, 32'(last_low[0]),  32'd128);
        chk("sclkAtRise", 0, 32'(sclk_at_rise[0]), 32'd1);
        chk("doneCntA",   0, 32'(done_cnt[0] - d0), 32'd1);
        chk("latA",       0, 32'(done_cyc[0] - k_rise), 32'd131);
        chk("wordA",      1, 32'(last_word[1]), 32'h3C1F);
        chk("wordA",      2, 32'(last_word[2]), 32'h0C1F);
        chk("latA",       2, 32'(done_cyc[2] - k_rise), 32'd35);

        // Power-down field in the frame
        pulse(12'h000, 2);
        repeat (150) tick();
        chk("wordPD",     1, 32'(last_word[1]), 32'h3000);
        chk("sclkAtRise", 1, 32'(sclk_at_rise[1]), 32'd1);
        chk("wordPD",     0, 32'(last_word[0]), 32'h0000);

        // Re-trigger mid-frame with a new code
        d0 = done_cnt[0];
        pulse(12'hC1F, 2);
        repeat (42) tick();
        u_in  = 12'hFFF;
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        repeat (150) tick();
        chk("wordRetrig", 0, 32'(last_word[0]), 32'h0C1F);
        chk("doneRetrig", 0, 32'(done_cnt[0] - d0), 32'd1);
        chk("wordRetrig", 2, 32'(last_word[2]), 32'h0FFF);

        // Start held high
        d0 = done_cnt[0]; d1 = done_cnt[1]; d2 = done_cnt[2];
        u_in  = 12'h5A5;
        start = 1'b1;
        repeat (500) tick();
        chk("doneHeld", 0, 32'(done_cnt[0] - d0), 32'd1);
        chk("doneHeld", 1, 32'(done_cnt[1] - d1), 32'd1);
        chk("doneHeld", 2, 32'(done_cnt[2] - d2), 32'd1);
        start = 1'b0;
        repeat (2) tick();
        pulse(12'h123, 2);
        repeat (150) tick();
        chk("doneReraise", 0, 32'(done_cnt[0] - d0), 32'd2);
        chk("wordReraise", 0, 32'(last_word[0]), 32'h0123);

        // Reset mid-frame
        pulse(12'hC1F, 2);
        repeat (66) tick();
        d0 = done_cnt[0];
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_sync_n", i, 32'(sync_n[i]), 32'd1);
            chk("midrst_sclk",   i, 32'(sclk[i]),   32'd1);
            chk("midrst_busy",   i, 32'(busy[i]),   32'd0);
            chk("midrst_done",   i, 32'(done[i]),   32'd0);
        end
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("midrst_noDone", 0, 32'(done_cnt[0] - d0), 32'd0);
        pulse(12'h5A5, 2);
        repeat (150) tick();
        chk("wordAfterRst", 0, 32'(last_word[0]), 32'h05A5);
        chk("lowAfterRst",  0, 32'(last_low[0]),  32'd128);

        // Fastest serial clock
        pulse(12'hAAA, 2);
        repeat (150) tick();
        chk("wordDiv1", 2, 32'(last_word[2]), 32'h0AAA);
        chk("lowDiv1",  2, 32'(last_low[2]),  32'd32);
        chk("latDiv1",  2, 32'(done_cyc[2] - k_rise), 32'd35);

        // Randomized start timing and code changes
        repeat (40) begin
            u_in  = 12'($urandom);
            start = 1'b1;
            repeat ($urandom_range(1, 4)) tick();
            start = 1'b0;
            gap = $urandom_range(1, 180);
            repeat (gap) begin
                if ($urandom_range(0, 7) == 0) u_in = 12'($urandom);
                tick();
            end
        end
        repeat (200) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
